// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, issues in-order requests to instruction memory, and buffers responses
// in a DEPTH-entry queue toward decode. Optional macro FETCH_ALIGN_CHK_EN flags misaligned redirects.
module fetch_queue #(
    parameter int                DATA_W          = 16,
    parameter int                ADDR_W          = 16,
    parameter int                DEPTH           = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0,
    parameter int                PC_INC          = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_pc_next,
    output logic              err
);

    localparam int QAW  = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [ADDR_W-1:0] L_PC_INC  = ADDR_W'(PC_INC);
    localparam logic [SW-1:0]     L_SF_LAST = SW'(MAX_OUTSTANDING - 1);
    localparam logic [SW-1:0]     L_SF_ONE  = SW'(1);
    localparam logic [OW-1:0]     L_O_ONE   = OW'(1);
    localparam logic [CNTW-1:0]   L_C_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0]   L_C_FULL  = CNTW'(DEPTH);
    localparam logic [QAW-1:0]    L_Q_ONE   = QAW'(1);

    logic [ADDR_W-1:0] r_pc;
    logic [OW-1:0]     r_out;
    logic [OW-1:0]     r_drop;
    logic              r_err;
    logic [CNTW-1:0]   r_count;
    logic [QAW-1:0]    r_wr;
    logic [QAW-1:0]    r_rd;
    logic [SW-1:0]     r_sf_wr;
    logic [SW-1:0]     r_sf_rd;

    logic [DATA_W-1:0] r_q_data [DEPTH];
    logic [ADDR_W-1:0] r_q_pc   [DEPTH];
    logic [ADDR_W-1:0] r_sf_pc  [MAX_OUTSTANDING];

    logic              w_inst_valid;
    logic              w_credit;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_rsp_ok;
    logic              w_rsp_orphan;
    logic              w_rsp_drop;
    logic              w_push_try;
    logic              w_full;
    logic              w_pop;
    logic              w_overflow;
    logic              w_push;
    logic              w_misalign;
    logic              w_err_set;
    logic [ADDR_W-1:0] w_rsp_pc;
    logic [OW-1:0]     w_out_next;
    logic [OW-1:0]     w_drop_next;
    logic [CNTW-1:0]   w_count_next;

    // Credit counts every in-flight request, including ones destined to be dropped,
    // so an accepted request always has a queue slot waiting for it.
    assign w_inst_valid = (r_count != '0);
    assign w_credit     = (int'(r_count) + int'(r_out)) < DEPTH;
    assign w_req_valid  = rst & ~halt & ~redirect & (int'(r_out) < MAX_OUTSTANDING) & w_credit;
    assign w_req_fire   = w_req_valid & imem_req_ready;

    assign w_rsp_ok     = imem_rsp_valid & (r_out != '0);
    assign w_rsp_orphan = imem_rsp_valid & (r_out == '0);
    assign w_rsp_drop   = w_rsp_ok & (r_drop != '0);
    assign w_rsp_pc     = r_sf_pc[r_sf_rd];

    assign w_full       = (r_count == L_C_FULL);
    assign w_pop        = w_inst_valid & inst_ready & ~redirect;
    assign w_push_try   = w_rsp_ok & ~w_rsp_drop & ~redirect;
    assign w_overflow   = w_push_try & w_full & ~w_pop;
    assign w_push       = w_push_try & ~w_overflow;

`ifdef FETCH_ALIGN_CHK_EN
    assign w_misalign = redirect & ((redirect_pc % L_PC_INC) != '0);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err_set = w_rsp_orphan | w_overflow | w_misalign;

    always_comb begin
        w_out_next = r_out;
        if (w_req_fire) w_out_next = w_out_next + L_O_ONE;
        if (w_rsp_ok)   w_out_next = w_out_next - L_O_ONE;

        w_drop_next = r_drop;
        if (redirect)        w_drop_next = w_out_next;
        else if (w_rsp_drop) w_drop_next = r_drop - L_O_ONE;

        w_count_next = r_count;
        if (w_push) w_count_next = w_count_next + L_C_ONE;
        if (w_pop)  w_count_next = w_count_next - L_C_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_out   <= '0;
            r_drop  <= '0;
            r_err   <= 1'b0;
            r_count <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_sf_wr <= '0;
            r_sf_rd <= '0;
        end else begin
            r_out  <= w_out_next;
            r_drop <= w_drop_next;
            r_err  <= r_err | w_err_set;

            if (redirect)        r_pc <= redirect_pc;
            else if (w_req_fire) r_pc <= r_pc + L_PC_INC;

            if (w_req_fire) r_sf_wr <= (r_sf_wr == L_SF_LAST) ? '0 : r_sf_wr + L_SF_ONE;
            if (w_rsp_ok)   r_sf_rd <= (r_sf_rd == L_SF_LAST) ? '0 : r_sf_rd + L_SF_ONE;

            if (redirect) begin
                r_count <= '0;
                r_wr    <= '0;
                r_rd    <= '0;
            end else begin
                r_count <= w_count_next;
                if (w_push) r_wr <= r_wr + L_Q_ONE;
                if (w_pop)  r_rd <= r_rd + L_Q_ONE;
            end
        end
    end

    // Storage carries no reset; validity is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr] <= imem_rsp_data;
            r_q_pc[r_wr]   <= w_rsp_pc;
        end
        if (w_req_fire) r_sf_pc[r_sf_wr] <= r_pc;
    end

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = r_pc;
    assign inst_valid     = w_inst_valid;
    assign inst           = w_inst_valid ? r_q_data[r_rd] : '0;
    assign inst_pc        = w_inst_valid ? r_q_pc[r_rd] : '0;
    assign inst_pc_next   = w_inst_valid ? (r_q_pc[r_rd] + L_PC_INC) : '0;
    assign err            = r_err;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a memory model answers requests in order with random latency,
// and a reference model of the fetch stream predicts every handshake, delivery and error flag.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [15:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [15:0] inst_pc_next;
    logic        err;

    fetch_queue dut (
        .clk           (clk),
        .rst           (rst),
        .halt          (halt),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_pc_next  (inst_pc_next),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] pc; logic [15:0] data; } sb_t;
    typedef struct packed { logic [15:0] pc; int gen; } fl_t;
    typedef struct packed { logic [15:0] addr; int due; } mem_t;

    sb_t  sb_q[$];
    fl_t  fl_q[$];
    mem_t mem_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int gen = 0;
    int lat_lo = 1;
    int lat_hi = 1;
    int last_due = 0;
    int due;
    logic [15:0] model_pc = 16'h0000;
    logic [15:0] nxt;
    logic        exp_err = 1'b0;
    logic        exp_req;
    sb_t         e;
    fl_t         f;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, compares against the model state, then advances the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
                check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
                check("rst_inst", {16'b0, inst}, 32'd0);
                check("rst_inst_pc", {16'b0, inst_pc}, 32'd0);
                check("rst_inst_pc_next", {16'b0, inst_pc_next}, 32'd0);
                check("rst_err", {31'b0, err}, 32'd0);
                sb_q.delete();
                fl_q.delete();
                mem_q.delete();
                model_pc = 16'h0000;
                exp_err = 1'b0;
                last_due = 0;
                gen++;
            end else begin
                exp_req = !halt && !redirect && (fl_q.size() < 2) && ((sb_q.size() + fl_q.size()) < 4);
                check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
                check("inst_valid", {31'b0, inst_valid}, {31'b0, sb_q.size() != 0});
                check("err", {31'b0, err}, {31'b0, exp_err});

                if (inst_valid && inst_ready && !redirect && sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    nxt = e.pc + 16'd2;
                    check("inst", {16'b0, inst}, {16'b0, e.data});
                    check("inst_pc", {16'b0, inst_pc}, {16'b0, e.pc});
                    check("inst_pc_next", {16'b0, inst_pc_next}, {16'b0, nxt});
                    $display("pop cyc=%0d pc=%h inst=%h", cyc, inst_pc, inst);
                end

                if (imem_rsp_valid) begin
                    if (fl_q.size() == 0) begin
                        exp_err = 1'b1;
                    end else begin
                        f = fl_q.pop_front();
                        if (f.gen == gen && !redirect) sb_q.push_back('{f.pc, memfn(f.pc)});
                    end
                end

                if (redirect) begin
                    sb_q.delete();
                    gen++;
                    model_pc = redirect_pc;
`ifdef FETCH_ALIGN_CHK_EN
                    if ((redirect_pc % 16'd2) != 16'd0) exp_err = 1'b1;
`endif
                end

                if (imem_req_valid && imem_req_ready) begin
                    check("imem_addr", {16'b0, imem_addr}, {16'b0, model_pc});
                    fl_q.push_back('{model_pc, gen});
                    due = cyc + int'($urandom_range(lat_hi, lat_lo));
                    if (due < last_due) due = last_due;
                    last_due = due;
                    mem_q.push_back('{imem_addr, due});
                    model_pc = model_pc + 16'd2;
                end
            end
        end
    end

    // Driver: one call per cycle; the memory returns the oldest request once its latency elapses.
    task automatic step(input logic h, input logic r, input logic [15:0] rp,
                        input logic qr, input logic ir);
        @(posedge clk);
        #1;
        cyc++;
        halt = h;
        redirect = r;
        redirect_pc = rp;
        imem_req_ready = qr;
        inst_ready = ir;
        if (rst && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = memfn(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data = 16'($urandom);
        end
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            lat_lo = 1;
            lat_hi = 3;
            step(($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 7) == 0) ? 16'hFFFC : (16'($urandom) & 16'hFFFE),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 7));
        end
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        rst = 1'b1;

        // Streaming with single-cycle memory, then a decode stall and release.
        lat_lo = 1; lat_hi = 1;
        repeat (20) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

        // Three-cycle memory with a redirect while requests are in flight.
        lat_lo = 3; lat_hi = 3;
        repeat (4) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h0100, 1'b1, 1'b1);
        repeat (15) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

        // PC wrap at the top of the address space.
        lat_lo = 1; lat_hi = 1;
        step(1'b0, 1'b1, 16'hFFFC, 1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

        // Halt with work in flight: queue drains, then fetch resumes sequentially.
        lat_lo = 2; lat_hi = 2;
        repeat (3) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        repeat (8) step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

        random_phase(1500);

        // Reset in the middle of traffic.
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        rst = 1'b0;
        repeat (2) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        rst = 1'b1;
        random_phase(500);

        // Misaligned redirect: flagged only when the alignment check is built in.
        lat_lo = 1; lat_hi = 1;
        step(1'b0, 1'b1, 16'h0101, 1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

        // Drain everything, then present a response with nothing outstanding.
        repeat (40) step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 16'h1234;
        repeat (4) step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
